// File: rtl/lcd_frame_writer_pkg.sv
// Shared state encoding and LCD protocol constants for the frame writer.
// Every byte constant used on the serial LCD stream is kept here.
package lcd_pkg;

    typedef enum logic [3:0] {
        IDLE,
        BL_PREFIX,
        BL_VALUE,
        L1_PREFIX,
        L1_ADDR,
        L1_CHARS,
        L2_PREFIX,
        L2_ADDR,
        L2_CHARS,
        GAP,
        DONE
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD    = 8'hFE;
    localparam logic [7:0] LCD_BL_CMD = 8'h7C;
    localparam logic [7:0] LINE1_ADDR = 8'h80;
    localparam logic [7:0] LINE2_ADDR = 8'hC0;
    localparam logic [7:0] BL_BASE    = 8'h80;
    localparam logic [4:0] BL_MAX     = 5'd29;
    localparam logic [7:0] SPACE_CHAR = 8'h20;

    function automatic logic [4:0] bl_sat(input logic [4:0] lvl);
        return (lvl > BL_MAX) ? BL_MAX : lvl;
    endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// Host-side buffer/request signals and FIFO-side byte stream of the frame writer.
// master = the controlling side, slave = the frame writer itself.
interface lcd_frame_writer_if;
    logic       buf_we;
    logic [4:0] buf_addr;
    logic [7:0] buf_data;
    logic       refresh;
    logic       bl_req;
    logic [4:0] bl_level;
    logic       fifo_wrfull;
    logic       fifo_wrreq;
    logic [7:0] fifo_data;
    logic       busy;
    logic       done;

    modport master (
        output buf_we, buf_addr, buf_data, refresh, bl_req, bl_level, fifo_wrfull,
        input  fifo_wrreq, fifo_data, busy, done
    );

    modport slave (
        input  buf_we, buf_addr, buf_data, refresh, bl_req, bl_level, fifo_wrfull,
        output fifo_wrreq, fifo_data, busy, done
    );
endinterface

// File: rtl/lcd_frame_buf.sv
// 32 x 8 character store: synchronous write, asynchronous read, clears to spaces.
// Kept as discrete registers so a reset can blank the whole frame in one cycle.
module lcd_frame_buf
    import lcd_pkg::*;
(
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] entry_q [32];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_entry
            logic [7:0] entry_reg;

            always_ff @(posedge CLK) begin
                if (!rst_n) begin
                    entry_reg <= SPACE_CHAR;
                end else if (we && (waddr == 5'(gi))) begin
                    entry_reg <= wdata;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign rdata = entry_q[raddr];

endmodule

// File: rtl/lcd_frame_writer.sv
// Streams the 2x16 character frame or a backlight command into a UART FIFO,
// with a fixed idle gap after each cursor/backlight command so the LCD can settle.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int CMD_GAP = 64
) (
    input  logic               CLK,
    input  logic               rst_n,
    lcd_frame_writer_if.slave  lcd
);

    localparam int GW = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((CMD_GAP > 0) ? (CMD_GAP - 1) : 0);

    lcd_state_t    state_reg, state_next;
    lcd_state_t    ret_reg, ret_next;
    lcd_state_t    gap_target;
    logic [3:0]    char_cnt_reg, char_cnt_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic [4:0]    level_reg, level_next;
    logic          refresh_pend_reg, refresh_pend_next;
    logic          bl_pend_reg, bl_pend_next;
    logic          refresh_clr, bl_clr;
    logic          emit, enter_gap;
    logic [7:0]    char_data;

    lcd_frame_buf u_frame_buf (
        .CLK   (CLK),
        .rst_n (rst_n),
        .we    (lcd.buf_we),
        .waddr (lcd.buf_addr),
        .wdata (lcd.buf_data),
        .raddr ({(state_reg == L2_CHARS), char_cnt_reg}),
        .rdata (char_data)
    );

    always_comb begin
        state_next    = state_reg;
        ret_next      = ret_reg;
        char_cnt_next = char_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        level_next    = level_reg;
        refresh_clr   = 1'b0;
        bl_clr        = 1'b0;
        emit          = 1'b0;
        enter_gap     = 1'b0;
        gap_target    = IDLE;
        lcd.fifo_data = 8'h00;

        case (state_reg)
            IDLE: begin
                if (bl_pend_reg) begin
                    state_next = BL_PREFIX;
                    bl_clr     = 1'b1;
                    level_next = bl_sat(lcd.bl_level);
                end else if (refresh_pend_reg) begin
                    state_next  = L1_PREFIX;
                    refresh_clr = 1'b1;
                end
            end
            BL_PREFIX: begin
                emit          = 1'b1;
                lcd.fifo_data = LCD_BL_CMD;
                if (!lcd.fifo_wrfull) state_next = BL_VALUE;
            end
            BL_VALUE: begin
                emit          = 1'b1;
                lcd.fifo_data = BL_BASE + 8'(level_reg);
                enter_gap     = !lcd.fifo_wrfull;
                gap_target    = DONE;
            end
            L1_PREFIX: begin
                emit          = 1'b1;
                lcd.fifo_data = LCD_CMD;
                if (!lcd.fifo_wrfull) state_next = L1_ADDR;
            end
            L1_ADDR: begin
                emit          = 1'b1;
                lcd.fifo_data = LINE1_ADDR;
                enter_gap     = !lcd.fifo_wrfull;
                gap_target    = L1_CHARS;
            end
            L1_CHARS: begin
                emit          = 1'b1;
                lcd.fifo_data = char_data;
                if (!lcd.fifo_wrfull) begin
                    char_cnt_next = char_cnt_reg + 4'd1;
                    if (char_cnt_reg == 4'd15) state_next = L2_PREFIX;
                end
            end
            L2_PREFIX: begin
                emit          = 1'b1;
                lcd.fifo_data = LCD_CMD;
                if (!lcd.fifo_wrfull) state_next = L2_ADDR;
            end
            L2_ADDR: begin
                emit          = 1'b1;
                lcd.fifo_data = LINE2_ADDR;
                enter_gap     = !lcd.fifo_wrfull;
                gap_target    = L2_CHARS;
            end
            L2_CHARS: begin
                emit          = 1'b1;
                lcd.fifo_data = char_data;
                if (!lcd.fifo_wrfull) begin
                    char_cnt_next = char_cnt_reg + 4'd1;
                    if (char_cnt_reg == 4'd15) state_next = DONE;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) state_next   = ret_reg;
                else                         gap_cnt_next = gap_cnt_reg + 1'b1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // A zero-length gap goes straight to the resume state.
        if (enter_gap) begin
            if (CMD_GAP == 0) begin
                state_next = gap_target;
            end else begin
                state_next   = GAP;
                ret_next     = gap_target;
                gap_cnt_next = '0;
            end
        end

        // A request seen on the clearing edge is kept for the next round.
        refresh_pend_next = lcd.refresh | (refresh_pend_reg & ~refresh_clr);
        bl_pend_next      = lcd.bl_req  | (bl_pend_reg & ~bl_clr);
    end

    assign lcd.fifo_wrreq = emit & ~lcd.fifo_wrfull;
    assign lcd.busy       = (state_reg != IDLE);
    assign lcd.done       = (state_reg == DONE);

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            ret_reg          <= IDLE;
            char_cnt_reg     <= '0;
            gap_cnt_reg      <= '0;
            level_reg        <= '0;
            refresh_pend_reg <= 1'b0;
            bl_pend_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            ret_reg          <= ret_next;
            char_cnt_reg     <= char_cnt_next;
            gap_cnt_reg      <= gap_cnt_next;
            level_reg        <= level_next;
            refresh_pend_reg <= refresh_pend_next;
            bl_pend_reg      <= bl_pend_next;
        end
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Self-checking bench: a step-queue model of the byte stream is compared every cycle,
// plus directed scenarios with hand-computed byte/cycle expectations.
module tb_lcd_frame_writer;

    localparam int GAP       = 64;
    localparam int STEP_GAP  = -1;
    localparam int STEP_DONE = -2;
    localparam int CHAR_BASE = 1000;

    logic CLK   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    lcd_frame_writer_if lcd();

    lcd_frame_writer #(.CMD_GAP(GAP)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .lcd   (lcd)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Model: each queued step is a fixed byte, a frame-buffer reference, a gap cycle or the done cycle.
    int         steps[$];
    bit         m_rp = 1'b0;
    bit         m_bp = 1'b0;
    logic [7:0] m_buf [32];
    logic [7:0] wlog[$];
    int         wcyc[$];
    int         dcyc[$];

    logic       exp_busy, exp_wr, exp_done;
    logic [7:0] exp_data;
    int         front;

    initial for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void add_gap();
        for (int i = 0; i < GAP; i++) steps.push_back(STEP_GAP);
    endfunction

    function automatic void add_refresh();
        steps.push_back('hFE);
        steps.push_back('h80);
        add_gap();
        for (int i = 0; i < 16; i++) steps.push_back(CHAR_BASE + i);
        steps.push_back('hFE);
        steps.push_back('hC0);
        add_gap();
        for (int i = 16; i < 32; i++) steps.push_back(CHAR_BASE + i);
        steps.push_back(STEP_DONE);
    endfunction

    function automatic void add_bl(input int lvl);
        steps.push_back('h7C);
        steps.push_back(128 + ((lvl > 29) ? 29 : lvl));
        add_gap();
        steps.push_back(STEP_DONE);
    endfunction

    always @(negedge CLK) begin
        exp_busy = (steps.size() != 0);
        exp_wr   = 1'b0;
        exp_done = 1'b0;
        exp_data = 8'h00;
        front    = STEP_GAP;
        if (exp_busy) begin
            front = steps[0];
            if (front >= CHAR_BASE) begin
                exp_wr   = !lcd.fifo_wrfull;
                exp_data = m_buf[5'(front - CHAR_BASE)];
            end else if (front >= 0) begin
                exp_wr   = !lcd.fifo_wrfull;
                exp_data = 8'(front);
            end else if (front == STEP_DONE) begin
                exp_done = 1'b1;
            end
        end
        check("busy", 32'(lcd.busy), 32'(exp_busy));
        check("wrreq", 32'(lcd.fifo_wrreq), 32'(exp_wr));
        check("done", 32'(lcd.done), 32'(exp_done));
        if (exp_wr) check("data", 32'(lcd.fifo_data), 32'(exp_data));

        if (lcd.fifo_wrreq === 1'b1) begin
            wlog.push_back(lcd.fifo_data);
            wcyc.push_back(cyc);
        end
        if (lcd.done === 1'b1) dcyc.push_back(cyc);

        // Advance the model across the coming rising edge.
        if (!rst_n) begin
            steps.delete();
            m_rp = 1'b0;
            m_bp = 1'b0;
            for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        end else begin
            if (exp_busy) begin
                if (front < 0 || !lcd.fifo_wrfull) void'(steps.pop_front());
            end else if (m_bp) begin
                add_bl(int'(lcd.bl_level));
                m_bp = 1'b0;
            end else if (m_rp) begin
                add_refresh();
                m_rp = 1'b0;
            end
            if (lcd.bl_req)  m_bp = 1'b1;
            if (lcd.refresh) m_rp = 1'b1;
            if (lcd.buf_we)  m_buf[lcd.buf_addr] = lcd.buf_data;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_logs();
        wlog.delete();
        wcyc.delete();
        dcyc.delete();
    endtask

    task automatic write_buf(input logic [4:0] a, input logic [7:0] d);
        lcd.buf_we   = 1'b1;
        lcd.buf_addr = a;
        lcd.buf_data = d;
        tick();
        lcd.buf_we   = 1'b0;
    endtask

    int req_cyc;
    task automatic pulse_refresh();
        lcd.refresh = 1'b1;
        req_cyc     = cyc;
        tick();
        lcd.refresh = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (dcyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("done_count", dcyc.size(), n);
        tick(2);
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k;
        k = 0;
        while (wlog.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("write_count_reached", wlog.size(), n);
    endtask

    logic [7:0] hello [5];
    int         n0;

    initial begin
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        lcd.buf_we = 1'b0; lcd.buf_addr = '0; lcd.buf_data = '0;
        lcd.refresh = 1'b0; lcd.bl_req = 1'b0; lcd.bl_level = '0; lcd.fifo_wrfull = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
        check("reset_busy", 32'(lcd.busy), 0);
        check("reset_wrreq", 32'(lcd.fifo_wrreq), 0);
        check("reset_done", 32'(lcd.done), 0);
        $display("reset: busy=%0b wrreq=%0b done=%0b", lcd.busy, lcd.fifo_wrreq, lcd.done);

        // HELLO frame with latency and gap timing
        for (int i = 0; i < 5; i++) write_buf(5'(i), hello[i]);
        clear_logs();
        pulse_refresh();
        wait_done(1, 400);
        check("hello_len", wlog.size(), 36);
        check("hello_b0", 32'(wlog[0]), 'hFE);
        check("hello_b1", 32'(wlog[1]), 'h80);
        for (int i = 0; i < 5; i++) check("hello_char", 32'(wlog[2 + i]), 32'(hello[i]));
        check("hello_b7", 32'(wlog[7]), 'h20);
        check("hello_b18", 32'(wlog[18]), 'hFE);
        check("hello_b19", 32'(wlog[19]), 'hC0);
        check("hello_b35", 32'(wlog[35]), 'h20);
        check("hello_gap1", wcyc[2] - wcyc[1], 65);
        check("hello_gap2", wcyc[20] - wcyc[19], 65);
        check("hello_latency", wcyc[0] - req_cyc, 2);
        $display("refresh HELLO: %0d bytes, %0d done pulses", wlog.size(), dcyc.size());

        // backlight saturation
        clear_logs();
        lcd.bl_level = 5'd31;
        lcd.bl_req   = 1'b1;
        tick();
        lcd.bl_req   = 1'b0;
        wait_done(1, 200);
        check("bl_len", wlog.size(), 2);
        check("bl_b0", 32'(wlog[0]), 'h7C);
        check("bl_b1", 32'(wlog[1]), 'h9D);
        check("bl_gap", dcyc[0] - wcyc[1], 65);
        $display("backlight 31: %0d bytes, second=%0h", wlog.size(), wlog[1]);

        // simultaneous requests: backlight first, one idle cycle, then refresh
        clear_logs();
        lcd.refresh = 1'b1;
        lcd.bl_req  = 1'b1;
        tick();
        lcd.refresh = 1'b0;
        lcd.bl_req  = 1'b0;
        wait_done(2, 600);
        check("both_len", wlog.size(), 38);
        check("both_b0", 32'(wlog[0]), 'h7C);
        check("both_b1", 32'(wlog[1]), 'h9D);
        check("both_b2", 32'(wlog[2]), 'hFE);
        check("both_b3", 32'(wlog[3]), 'h80);
        check("both_idle", wcyc[2] - dcyc[0], 2);
        $display("bl+refresh: %0d bytes, %0d done pulses", wlog.size(), dcyc.size());

        // FIFO full at line-1 char 5
        for (int i = 0; i < 32; i++) write_buf(5'(i), 8'(8'h41 + i));
        clear_logs();
        pulse_refresh();
        wait_writes(7, 300);
        lcd.fifo_wrfull = 1'b1;
        tick(10);
        lcd.fifo_wrfull = 1'b0;
        wait_done(1, 400);
        check("full_len", wlog.size(), 36);
        for (int i = 0; i < 16; i++) begin
            check("full_l1", 32'(wlog[2 + i]), 32'(8'h41 + i));
            check("full_l2", 32'(wlog[20 + i]), 32'(8'h51 + i));
        end
        check("full_stall", wcyc[7] - wcyc[6], 11);
        $display("full stall: %0d bytes, stall span %0d", wlog.size(), wcyc[7] - wcyc[6]);

        // reset mid line 2
        clear_logs();
        pulse_refresh();
        wait_writes(28, 400);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_busy", 32'(lcd.busy), 0);
        check("rst_wrreq", 32'(lcd.fifo_wrreq), 0);
        n0 = wlog.size();
        tick(20);
        check("rst_no_resume", wlog.size(), n0);
        clear_logs();
        pulse_refresh();
        wait_done(1, 400);
        check("rst_len", wlog.size(), 36);
        check("rst_b0", 32'(wlog[0]), 'hFE);
        check("rst_b1", 32'(wlog[1]), 'h80);
        for (int i = 0; i < 16; i++) begin
            check("rst_space_l1", 32'(wlog[2 + i]), 'h20);
            check("rst_space_l2", 32'(wlog[20 + i]), 'h20);
        end
        $display("reset mid-frame: refresh after reset sent %0d bytes", wlog.size());

        // repeated requests during a frame merge into one more frame
        clear_logs();
        pulse_refresh();
        tick(30);
        pulse_refresh();
        tick(40);
        pulse_refresh();
        tick(50);
        pulse_refresh();
        wait_done(2, 800);
        tick(300);
        check("merge_done", dcyc.size(), 2);
        check("merge_len", wlog.size(), 72);
        $display("merged refresh: %0d bytes, %0d done pulses", wlog.size(), dcyc.size());

        // randomized traffic against the model
        clear_logs();
        for (int i = 0; i < 4000; i++) begin
            lcd.buf_we      = ($urandom_range(3) == 0);
            lcd.buf_addr    = 5'($urandom_range(31));
            lcd.buf_data    = 8'($urandom_range(255));
            lcd.refresh     = ($urandom_range(149) == 0);
            lcd.bl_req      = ($urandom_range(299) == 0);
            lcd.bl_level    = 5'($urandom_range(31));
            lcd.fifo_wrfull = ($urandom_range(2) == 0);
            tick();
        end
        lcd.buf_we = 1'b0; lcd.refresh = 1'b0; lcd.bl_req = 1'b0; lcd.fifo_wrfull = 1'b0;
        tick(600);
        check("random_idle", 32'(lcd.busy), 0);
        $display("random traffic: %0d bytes, %0d done pulses", wlog.size(), dcyc.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
